// File: rtl/fp_pkg.sv
// Shared single-precision types, result classification and divider constants.
// Used by the multiplier and the divider so status encodings stay identical.
package fp_pkg;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exponent;
    logic [22:0] mantissa;
  } fp_t;

  typedef enum logic [2:0] {
    normalizedNumber  = 3'd0,
    zero              = 3'd1,
    positive_infinity = 3'd2,
    negative_infinity = 3'd3,
    nan               = 3'd4,
    overflow          = 3'd5,
    underflow         = 3'd6,
    div_by_zero       = 3'd7
  } fp_status_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    ROUND  = 2'd2,
    DONE   = 2'd3
  } div_state_e;

  localparam int          FP_BIAS   = 127;
  localparam logic [31:0] FP_QNAN   = 32'h7FC00000;
  localparam int          DIV_QBITS = 26;

endpackage

// File: rtl/fp_mant_div_core.sv
// Restoring mantissa divider: one quotient bit per clock, DIV_QBITS bits per start.
// q[25] is the integer bit; rem_nz reports a nonzero final remainder for sticky.
module fp_mant_div_core
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [23:0] dividend,
  input  logic [23:0] divisor,
  output logic        done,
  output logic [25:0] q,
  output logic        rem_nz
);

  // Remainder stays below twice the divisor, so 25 bits never overflow.
  logic [24:0] rem;
  logic [23:0] dvs;
  logic [25:0] q_r;
  logic [4:0]  cnt;
  logic        busy;
  logic        ge;
  logic [24:0] rem_next;

  always_comb begin
    ge       = (rem >= {1'b0, dvs});
    rem_next = ge ? (rem - {1'b0, dvs}) : rem;
    rem_next = {rem_next[23:0], 1'b0};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem  <= '0;
      dvs  <= '0;
      q_r  <= '0;
      cnt  <= '0;
      busy <= 1'b0;
    end else if (start) begin
      rem  <= {1'b0, dividend};
      dvs  <= divisor;
      q_r  <= '0;
      cnt  <= '0;
      busy <= 1'b1;
    end else if (busy) begin
      rem <= rem_next;
      q_r <= {q_r[24:0], ge};
      cnt <= cnt + 5'd1;
      if (cnt == 5'(DIV_QBITS - 1)) busy <= 1'b0;
    end
  end

  assign done   = busy && (cnt == 5'(DIV_QBITS - 1));
  assign q      = q_r;
  assign rem_nz = |rem;

endmodule

// File: rtl/fp_divider.sv
// Sequential single-precision divider with valid/ready on both sides.
// Normal results appear 27 edges after accept, special cases 1 edge after accept.
module fp_divider
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output fp_status_e  status
);

  localparam logic signed [9:0] BIAS10 = 10'(FP_BIAS);

  div_state_e        state, state_n;
  fp_t               fa, fb;
  logic              sign_q, special_q, start;
  logic signed [9:0] exp_diff_q, exp_diff_in;
  logic [31:0]       result_q;
  fp_status_e        status_q;

  logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, sign_in;
  logic              is_special;
  logic [31:0]       spec_res;
  fp_status_e        spec_stat;

  logic              core_done, rem_nz;
  logic [25:0]       q;

  assign fa = a;
  assign fb = b;
  assign sign_in     = fa.sign ^ fb.sign;
  assign exp_diff_in = $signed({2'b00, fa.exponent}) - $signed({2'b00, fb.exponent});

  // Denormals count as zero: any exponent of 0 is treated as a zero operand.
  assign a_zero = (fa.exponent == 8'h00);
  assign b_zero = (fb.exponent == 8'h00);
  assign a_inf  = (fa.exponent == 8'hFF) && (fa.mantissa == 23'h0);
  assign b_inf  = (fb.exponent == 8'hFF) && (fb.mantissa == 23'h0);
  assign a_nan  = (fa.exponent == 8'hFF) && (fa.mantissa != 23'h0);
  assign b_nan  = (fb.exponent == 8'hFF) && (fb.mantissa != 23'h0);

  always_comb begin
    is_special = 1'b1;
    spec_res   = FP_QNAN;
    spec_stat  = nan;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      spec_res  = FP_QNAN;
      spec_stat = nan;
    end else if (b_zero && !a_inf) begin
      spec_res  = {sign_in, 8'hFF, 23'h0};
      spec_stat = div_by_zero;
    end else if (a_inf) begin
      spec_res  = {sign_in, 8'hFF, 23'h0};
      spec_stat = sign_in ? negative_infinity : positive_infinity;
    end else if (b_inf || a_zero) begin
      spec_res  = {sign_in, 31'h0};
      spec_stat = zero;
    end else begin
      is_special = 1'b0;
    end
  end

  fp_mant_div_core u_core (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .dividend ({1'b1, fa.mantissa}),
    .divisor  ({1'b1, fb.mantissa}),
    .done     (core_done),
    .q        (q),
    .rem_nz   (rem_nz)
  );

  logic [22:0]       mant_t;
  logic              guard, sticky, round_up;
  logic [23:0]       mant_r;
  logic signed [9:0] exp_t, exp_r;
  logic [31:0]       rnd_res;
  fp_status_e        rnd_stat;

  always_comb begin
    if (q[25]) begin
      mant_t = q[24:2];
      guard  = q[1];
      sticky = q[0] | rem_nz;
      exp_t  = exp_diff_q + BIAS10;
    end else begin
      mant_t = q[23:1];
      guard  = q[0];
      sticky = rem_nz;
      exp_t  = exp_diff_q + BIAS10 - 10'sd1;
    end
    round_up = guard & (sticky | mant_t[0]);
    mant_r   = {1'b0, mant_t} + {23'h0, round_up};
    // A carry out leaves mant_r[22:0] at zero, which is the required mantissa.
    exp_r    = exp_t + (mant_r[23] ? 10'sd1 : 10'sd0);
    if (exp_r >= 10'sd255) begin
      rnd_res  = {sign_q, 8'hFF, 23'h0};
      rnd_stat = overflow;
    end else if (exp_r <= 10'sd0) begin
      rnd_res  = {sign_q, 31'h0};
      rnd_stat = underflow;
    end else begin
      rnd_res  = {sign_q, exp_r[7:0], mant_r[22:0]};
      rnd_stat = normalizedNumber;
    end
  end

  // Specials also pass through ROUND so their result lands one edge after accept.
  always_comb begin
    state_n = state;
    start   = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          if (is_special) begin
            state_n = ROUND;
          end else begin
            state_n = DIVIDE;
            start   = 1'b1;
          end
        end
      end
      DIVIDE: if (core_done) state_n = ROUND;
      ROUND:  state_n = DONE;
      DONE:   if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sign_q     <= 1'b0;
      special_q  <= 1'b0;
      exp_diff_q <= '0;
      result_q   <= 32'h0;
      status_q   <= zero;
    end else begin
      state <= state_n;
      if (state == IDLE && in_valid) begin
        sign_q     <= sign_in;
        exp_diff_q <= exp_diff_in;
        special_q  <= is_special;
        if (is_special) begin
          result_q <= spec_res;
          status_q <= spec_stat;
        end
      end
      if (state == ROUND && !special_q) begin
        result_q <= rnd_res;
        status_q <= rnd_stat;
      end
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign result    = result_q;
  assign status    = status_q;

  a_in_known: assert property (@(posedge clk) disable iff (rst)
    in_valid |-> !$isunknown({a, b}));
  a_out_known: assert property (@(posedge clk) disable iff (rst)
    out_valid |-> !$isunknown({result, status}));
  a_out_stable: assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready) |=> ($stable(result) && $stable(status) && out_valid));

endmodule

// File: tb/tb_fp_divider.sv
// Directed bench for fp_divider: hand-computed quotients, latency, backpressure and reset.
module tb_fp_divider;
  import fp_pkg::*;

  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready;
  logic [31:0] a, b;
  logic        in_ready, out_valid;
  logic [31:0] result;
  fp_status_e  status;

  int checks = 0;
  int errors = 0;

  fp_divider dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .status    (status)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one operation, measure edges to out_valid, optionally stall, then drain.
  task automatic run_op(input string tag, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] er, input fp_status_e es, input int el,
                        input int hold);
    int lat;
    chk({tag, " in_ready before"}, 32'(in_ready), 32'd1);
    a = x;
    b = y;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, " latency"}, 32'(lat), 32'(el));
    chk({tag, " result"}, result, er);
    chk({tag, " status"}, 32'(status), 32'(es));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk({tag, " held result"}, result, er);
      chk({tag, " held out_valid"}, 32'(out_valid), 32'd1);
      chk({tag, " held in_ready"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk({tag, " out_valid after drain"}, 32'(out_valid), 32'd0);
    chk({tag, " in_ready after drain"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic seen;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = 32'h0;
    b = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset result", result, 32'h0);
    chk("reset status", 32'(status), 32'(zero));
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_op("6/2",       32'h40C00000, 32'h40000000, 32'h40400000, normalizedNumber, 27, 0);
    run_op("1/3",       32'h3F800000, 32'h40400000, 32'h3EAAAAAB, normalizedNumber, 27, 0);
    run_op("-1/3",      32'hBF800000, 32'h40400000, 32'hBEAAAAAB, normalizedNumber, 27, 0);
    run_op("1/0",       32'h3F800000, 32'h00000000, 32'h7F800000, div_by_zero,       1, 0);
    run_op("-1/0",      32'hBF800000, 32'h00000000, 32'hFF800000, div_by_zero,       1, 0);
    run_op("0/0",       32'h00000000, 32'h00000000, 32'h7FC00000, nan,               1, 0);
    run_op("inf/inf",   32'h7F800000, 32'h7F800000, 32'h7FC00000, nan,               1, 0);
    run_op("nan/1",     32'h7F800001, 32'h3F800000, 32'h7FC00000, nan,               1, 0);
    run_op("inf/2",     32'h7F800000, 32'h40000000, 32'h7F800000, positive_infinity, 1, 0);
    run_op("-inf/2",    32'hFF800000, 32'h40000000, 32'hFF800000, negative_infinity, 1, 0);
    run_op("2/inf",     32'h40000000, 32'h7F800000, 32'h00000000, zero,              1, 0);
    run_op("denorm/2",  32'h00000001, 32'h40000000, 32'h00000000, zero,              1, 0);
    run_op("overflow",  32'h7F000000, 32'h3F000000, 32'h7F800000, overflow,         27, 0);
    run_op("underflow", 32'h00800000, 32'h40000000, 32'h00000000, underflow,        27, 0);
    run_op("stall 6/2", 32'h40C00000, 32'h40000000, 32'h40400000, normalizedNumber, 27, 10);

    // Abort a divide with reset on the tenth edge after accept.
    a = 32'h40C00000;
    b = 32'h40000000;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("abort in_ready", 32'(in_ready), 32'd1);
    chk("abort out_valid", 32'(out_valid), 32'd0);
    chk("abort result", result, 32'h0);
    seen = 1'b0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    chk("abort no output", 32'(seen), 32'd0);

    run_op("6/2 after abort", 32'h40C00000, 32'h40000000, 32'h40400000, normalizedNumber, 27, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_divider.md
Name: fp_divider

Overview:
- Sequential IEEE-754 single-precision divider (result = a / b). It is the inverse-operation companion to the combinational multiplier.
- Iterative restoring mantissa division, one quotient bit per cycle.
- Valid/ready handshake on both input and output.
- Shares the fp struct and special-case status enum with the multiplier via the common package.

Parameters:
- None. Format is fixed at single precision; widths and constants live in the package.

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands a, b valid
- in_ready  output  1  divider idle, can accept
- a  input  32 (fp)  dividend
- b  input  32 (fp)  divisor
- out_valid  output  1  result/status valid
- out_ready  input  1  consumer accepts result
- result  output  32 (fp)  quotient
- status  output  3 (fp_status_e)  classification of result

Behaviour:
- Clocking/reset: one clock; reset is synchronous and active-high.
- rst values at the next edge: state=IDLE, in_ready=1, out_valid=0, result=32'h0, status=zero. rst mid-operation aborts the operation; no output is produced for it.
- States: IDLE, DIVIDE, ROUND, DONE. in_ready=1 only in IDLE; out_valid=1 only in DONE.
- Accept edge E0 (IDLE, in_valid=1): latch operands, sign=a.sign^b.sign, then classify:
  - Special case: set result/status, go to DONE.
  - Normal: go to DIVIDE.
- Input classes:
  - Denormal inputs (exp=0, man!=0) are flushed to zero before classification.
  - NaN = exp 255, man!=0. Inf = exp 255, man=0.
- Special-case priority (highest first):
  1. Either input NaN, 0/0, or inf/inf: result 32'h7FC00000, status nan.
  2. finite nonzero / 0: result {sign, 8'hFF, 0}, status div_by_zero.
  3. inf / finite: result ±inf, status positive_infinity or negative_infinity by sign.
  4. finite / inf, or 0 / finite nonzero: result {sign, 31'h0}, status zero.
- DIVIDE (edges E1..E26): restoring division.
  - Dividend and divisor are {1, man}; remainder initialises to the dividend.
  - Each edge: trial subtract the divisor, set the quotient bit, shift the remainder left.
  - This produces q[25:0], with q[25] as the integer bit. After E26, go to ROUND.
- ROUND (edge E27):
  - If q[25]=1: mant=q[24:2], guard=q[1], sticky=q[0] | (rem!=0), exp = ea - eb + 127.
  - Else: mant=q[23:1], guard=q[0], sticky=(rem!=0), exp = ea - eb + 126.
  - Rounding is round-to-nearest-even: increment if guard & (sticky | mant[0]). A mantissa carry-out gives mant=0 and exp+1.
  - Exponent arithmetic is 10-bit signed.
  - exp >= 255: result ±inf, status overflow.
  - exp <= 0: result ±0 (flush), status underflow.
  - Otherwise: result {sign, exp[7:0], mant}, status normalizedNumber.
  - Go to DONE.
- Latency:
  - Normal operations: out_valid high from E27 (27 cycles after accept).
  - Special cases: out_valid high from E1.
- DONE:
  - result and status are held stable while out_valid=1 and out_ready=0, for an unbounded time.
  - On the edge where out_valid & out_ready: go to IDLE, out_valid=0. in_ready is high in the following cycle.
  - No overlap of operations: minimum issue interval is 29 cycles (normal) or 3 cycles (special).
- in_valid while in_ready=0 is ignored; operands are not captured.
- Assertions: in_valid=1 implies a and b known; out_valid=1 implies result and status known; result and status are stable under backpressure.

Decomposition:
- Package fp_pkg contains:
  - fp packed struct (sign, exponent[7:0], mantissa[22:0]).
  - fp_status_e enum: normalizedNumber, zero, positive_infinity, negative_infinity, nan, overflow, underflow, div_by_zero.
  - Constants: FP_BIAS=127, FP_QNAN=32'h7FC00000, DIV_QBITS=26.
- One sub-module, fp_mant_div_core, owns the remainder register, quotient shift register and iteration counter.
  - Inputs: start, dividend[23:0], divisor[23:0].
  - Outputs: done pulse, q[25:0], rem_nz.
  - The top level holds the FSM, classification, rounding and handshake.

Test Plan:
- Basic divide: 32'h40C00000 / 32'h40000000 (6/2) -> 32'h40400000, status normalizedNumber, out_valid exactly 27 cycles after the accept edge.
- Rounding: 32'h3F800000 / 32'h40400000 (1/3) -> 32'h3EAAAAAB (RNE round-up). Also 32'hBF800000 / 32'h40400000 -> 32'hBEAAAAAB.
- Divide by zero: 32'h3F800000 / 32'h00000000 -> 32'h7F800000, status div_by_zero, latency 1. Also 32'hBF800000 / 32'h00000000 -> 32'hFF800000.
- NaN cases: 0/0, 32'h7F800000 / 32'h7F800000, and 32'h7F800001 / 32'h3F800000 each -> 32'h7FC00000, status nan.
- Range limits:
  - Overflow: 32'h7F000000 / 32'h3F000000 -> 32'h7F800000, status overflow.
  - Underflow: 32'h00800000 / 32'h40000000 -> 32'h00000000, status underflow.
- Backpressure and reset:
  - Hold out_ready=0 for 10 cycles -> result and out_valid stable, in_ready=0.
  - Assert rst at E10 of a DIVIDE -> next cycle in_ready=1, out_valid=0.
  - A following 6/2 operation still returns 32'h40400000.
